// File: rtl/seg_display_ctrl.sv
// 5-digit seven-segment controller: iterative double-dabble BCD, active-low segs.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_display_ctrl #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 5,
    parameter int BCD_W  = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic                overflow,
    output logic [7*DIGITS-1:0] segs
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int NIBS  = BCD_W / 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   sr;
    logic [DATA_W-1:0]   sr_sh;
    logic [DATA_W-1:0]   pend_data;
    logic                pend_v;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_sh;
    logic [DIGITS-1:0]   dig_on;
    logic [7*DIGITS-1:0] segs_nxt;
    logic                last_shift;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    assign busy       = (state != IDLE);
    assign last_shift = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_en || pend_v) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_nxt = LOAD;
                end
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble, then one combined left shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NIBS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign {bcd_sh, sr_sh} = {bcd_adj, sr} << 1;

    always_comb begin
        dig_on = '1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (bcd[4*i +: 4] != 4'd0) begin
                    seen = 1'b1;
                end
                dig_on[i] = seen;
            end
        end
`endif
    end

    always_comb begin
        segs_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_on[i]) begin
                segs_nxt[7*i +: 7] = decode(bcd[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            sr        <= '0;
            bcd       <= '0;
            pend_v    <= 1'b0;
            pend_data <= '0;
            segs      <= '1;
            overflow  <= 1'b0;
        end else begin
            // Writes arriving mid-conversion park in the pending slot.
            if (wr_en && state != IDLE) begin
                pend_v    <= 1'b1;
                pend_data <= wr_data;
            end
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        sr     <= wr_data;
                        bcd    <= '0;
                        cnt    <= '0;
                        pend_v <= 1'b0;
                    end else if (pend_v) begin
                        sr     <= pend_data;
                        bcd    <= '0;
                        cnt    <= '0;
                        pend_v <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd <= bcd_sh;
                    sr  <= sr_sh;
                    cnt <= cnt + 1'b1;
                end
                LOAD: begin
                    segs     <= segs_nxt;
                    overflow <= |bcd[BCD_W-1:4*DIGITS];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl.
// Expected patterns come from a decimal-digit model and a local decode table.
module tb_seg_display_ctrl;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        busy;
    logic        overflow;
    logic [34:0] segs;

    int n_checks;
    int n_fail;

    logic [34:0] blank;

    seg_display_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .busy     (busy),
        .overflow (overflow),
        .segs     (segs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] pat(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'b1000000;
            1: p = 7'b1111001;
            2: p = 7'b0100100;
            3: p = 7'b0110000;
            4: p = 7'b0011001;
            5: p = 7'b0010010;
            6: p = 7'b0000010;
            7: p = 7'b1111000;
            8: p = 7'b0000000;
            9: p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // shown: the 5-digit number expected on the display
    function automatic logic [34:0] exp_segs(input int unsigned shown);
        logic [34:0] r;
        int unsigned v;
        int dg [5];
        bit seen;
        v = shown;
        for (int i = 0; i < 5; i++) begin
            dg[i] = int'(v % 10);
            v = v / 10;
        end
        r = '1;
        seen = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (dg[i] != 0) seen = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (seen || i == 0) r[7*i +: 7] = pat(dg[i]);
`else
            r[7*i +: 7] = pat(dg[i]);
`endif
        end
        return r;
    endfunction

    // Leaves the bench 1 time unit after the edge E0 that sampled wr_en.
    task automatic do_write(input logic [31:0] v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = v;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0",
                     tag, busy, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (segs !== blank) begin
            n_fail++;
            $display("FAIL reset_segs: got %h, required %h", segs, blank);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b, required 0", overflow);
        end
    endtask

    task automatic test_basic();
        int edges;
        logic [34:0] exp;
        exp = {pat(1), pat(2), pat(3), pat(4), pat(5)};
        do_write(32'd12345);
        // edges counts E0..E33 inclusive
        edges = 1;
        while (busy && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 33) begin
                n_checks++;
                if (segs !== blank) begin
                    n_fail++;
                    $display("FAIL basic_early: got %h at E32, required %h",
                             segs, blank);
                end
            end
        end
        n_checks++;
        if (edges !== 34) begin
            n_fail++;
            $display("FAIL basic_busy_len: got %0d, required 34", edges);
        end
        n_checks++;
        if (segs !== exp) begin
            n_fail++;
            $display("FAIL basic_segs: got %h, required %h", segs, exp);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ovf: got %b, required 0", overflow);
        end
    endtask

    task automatic test_truncation();
        logic [31:0] vin [3];
        int unsigned shown [3];
        logic        ovf [3];
        vin[0] = 32'd123456;     shown[0] = 23456; ovf[0] = 1'b1;
        vin[1] = 32'hFFFFFFFF;   shown[1] = 67295; ovf[1] = 1'b1;
        vin[2] = 32'd99999;      shown[2] = 99999; ovf[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_write(vin[i]);
            wait_idle("trunc");
            n_checks++;
            if (segs !== exp_segs(shown[i])) begin
                n_fail++;
                $display("FAIL trunc_segs[%0d]: got %h, required %h",
                         i, segs, exp_segs(shown[i]));
            end
            n_checks++;
            if (overflow !== ovf[i]) begin
                n_fail++;
                $display("FAIL trunc_ovf[%0d]: got %b, required %b",
                         i, overflow, ovf[i]);
            end
        end
    endtask

    task automatic test_pending();
        logic [34:0] prev;
        prev = segs;
        do_write(32'd7);
        repeat (4) @(posedge clk);
        do_write(32'd42);
        repeat (4) @(posedge clk);
        do_write(32'd99);
        // now at E10+1
        repeat (22) @(posedge clk);
        #1;
        n_checks++;
        if (segs !== prev) begin
            n_fail++;
            $display("FAIL pend_hold7: got %h at E32, required %h", segs, prev);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (segs !== exp_segs(7)) begin
            n_fail++;
            $display("FAIL pend_seven: got %h, required %h", segs, exp_segs(7));
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_restart: busy=%b at E34, required 1", busy);
        end
        repeat (32) @(posedge clk);
        #1;
        n_checks++;
        if (segs !== exp_segs(7)) begin
            n_fail++;
            $display("FAIL pend_hold99: got %h at E66, required %h",
                     segs, exp_segs(7));
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (segs !== exp_segs(99)) begin
            n_fail++;
            $display("FAIL pend_99: got %h at E67, required %h",
                     segs, exp_segs(99));
        end
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || segs !== exp_segs(99)) begin
            n_fail++;
            $display("FAIL pend_no42: busy=%b segs=%h, required 0 and %h",
                     busy, segs, exp_segs(99));
        end
    endtask

    task automatic test_reset_mid();
        do_write(32'd555);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (segs !== blank || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: segs=%h busy=%b, required %h and 0",
                     segs, busy, blank);
        end
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (segs !== blank || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_residue: segs=%h busy=%b, required %h and 0",
                     segs, busy, blank);
        end
        do_write(32'd8);
        wait_idle("mid");
        n_checks++;
        if (segs !== exp_segs(8) || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_eight: segs=%h ovf=%b, required %h and 0",
                     segs, overflow, exp_segs(8));
        end
    endtask

    task automatic test_zero_leading();
        logic [34:0] e0;
        logic [34:0] e42;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        e0  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, pat(0)};
        e42 = {7'h7F, 7'h7F, 7'h7F, pat(4), pat(2)};
`else
        e0  = {pat(0), pat(0), pat(0), pat(0), pat(0)};
        e42 = {pat(0), pat(0), pat(0), pat(4), pat(2)};
`endif
        do_write(32'd0);
        wait_idle("zero");
        n_checks++;
        if (segs !== e0) begin
            n_fail++;
            $display("FAIL zero_segs: got %h, required %h", segs, e0);
        end
        do_write(32'd42);
        wait_idle("lead");
        n_checks++;
        if (segs !== e42) begin
            n_fail++;
            $display("FAIL lead_segs: got %h, required %h", segs, e42);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL lead_ovf: got %b, required 0", overflow);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        blank    = '1;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        test_reset();
        test_basic();
        test_truncation();
        test_pending();
        test_reset_mid();
        test_zero_leading();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
